pipe_stage_reg: RTL

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

---
 rtl/pipe_stage_reg_pkg.sv | 44 ++++
 rtl/pipe_stage_reg_sat_counter.sv | 23 ++
 rtl/pipe_stage_reg.sv | 119 +++++++++++
 3 files changed

// File: rtl/pipe_stage_reg_pkg.sv
// Shared definitions for the MEM/WB pipeline stage register:
// field widths, payload packing and the skid-buffer state encoding.
package pipe_stage_reg_pkg;

    // Datapath and register-file address widths of the core
    localparam int unsigned REG_WIDTH      = 32;
    localparam int unsigned REG_ADDR_WIDTH = 5;
    localparam int unsigned OPCODE_WIDTH   = 7;
    localparam int unsigned WB_SEL_WIDTH   = 1;

    // alu_out + dataB + opcode + rs1 + rs2 + rd + reg_write_en + wb_sel
    localparam int unsigned MEM_WB_WIDTH =
        2 * REG_WIDTH + OPCODE_WIDTH + 3 * REG_ADDR_WIDTH + 1 + WB_SEL_WIDTH;

    // Skid-buffer occupancy states; encoding equals the entry count
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } stage_state_e;

    // MEM/WB bundle as carried through the stage
    typedef struct packed {
        logic [REG_WIDTH-1:0]      alu_out;
        logic [REG_WIDTH-1:0]      data_b;
        logic [OPCODE_WIDTH-1:0]   opcode;
        logic [REG_ADDR_WIDTH-1:0] rs1;
        logic [REG_ADDR_WIDTH-1:0] rs2;
        logic [REG_ADDR_WIDTH-1:0] rd;
        logic                      reg_write_en;
        logic [WB_SEL_WIDTH-1:0]   wb_sel;
    } mem_wb_t;

    // Flatten the MEM/WB fields into the stage payload vector
    function automatic logic [MEM_WB_WIDTH-1:0] pack_mem_wb(input mem_wb_t f);
        return f;
    endfunction

    // Recover the MEM/WB fields from a stage payload vector
    function automatic mem_wb_t unpack_mem_wb(input logic [MEM_WB_WIDTH-1:0] p);
        return mem_wb_t'(p);
    endfunction

endpackage

// File: rtl/pipe_stage_reg_sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module sat_counter #(
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 inc,
    input  logic                 clr,
    output logic [CNT_WIDTH-1:0] cnt
);

    // Count up on inc, stick at all-ones, clear has priority
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// MEM/WB pipeline stage register built as a 2-entry skid buffer.
// in_ready is registered so there is no combinational path from out_ready;
// the skid entry absorbs the one transfer that arrives while the stage fills.
module pipe_stage_reg
    import pipe_stage_reg_pkg::*;
#(
    parameter int unsigned PAYLOAD_WIDTH = MEM_WB_WIDTH,
    parameter int unsigned CNT_WIDTH     = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [PAYLOAD_WIDTH-1:0] in_payload,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [PAYLOAD_WIDTH-1:0] out_payload,
    input  logic                     flush,
    output logic [1:0]               occupancy,
    input  logic                     cnt_clr,
    output logic [CNT_WIDTH-1:0]     stall_cnt
);

    stage_state_e             state_q, state_d;
    logic [PAYLOAD_WIDTH-1:0] main_q, main_d;
    logic [PAYLOAD_WIDTH-1:0] skid_q, skid_d;
    logic                     in_ready_d;
    logic                     out_valid_d;
    logic [1:0]               occ_d;
    logic                     accept;
    logic                     drain;
    logic                     stall;

    assign accept      = in_valid & in_ready;
    assign drain       = out_valid & out_ready;
    assign stall       = out_valid & ~out_ready;
    assign out_payload = main_q;

    // Next-state and payload movement; flush overrides every other event
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = ST_EMPTY;
            main_d  = '0;
            skid_d  = '0;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        main_d  = in_payload;
                        state_d = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (accept && drain) begin
                        main_d = in_payload;
                    end else if (drain) begin
                        state_d = ST_EMPTY;
                    end else if (accept) begin
                        skid_d  = in_payload;
                        state_d = ST_TWO;
                    end
                end
                ST_TWO: begin
                    if (drain) begin
                        main_d  = skid_q;
                        state_d = ST_ONE;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end
    end

    // Handshake outputs are decoded from the next state so they update with it
    always_comb begin
        in_ready_d  = (state_d != ST_TWO);
        out_valid_d = (state_d != ST_EMPTY);
        case (state_d)
            ST_ONE:  occ_d = 2'd1;
            ST_TWO:  occ_d = 2'd2;
            default: occ_d = 2'd0;
        endcase
    end

    // State, payload and registered handshake outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_EMPTY;
            main_q    <= '0;
            skid_q    <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            occupancy <= 2'd0;
        end else begin
            state_q   <= state_d;
            main_q    <= main_d;
            skid_q    <= skid_d;
            in_ready  <= in_ready_d;
            out_valid <= out_valid_d;
            occupancy <= occ_d;
        end
    end

    sat_counter #(
        .CNT_WIDTH(CNT_WIDTH)
    ) u_stall_cnt (
        .clk    (clk),
        .reset_n(reset_n),
        .inc    (stall),
        .clr    (cnt_clr),
        .cnt    (stall_cnt)
    );

endmodule
